// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, default
// latencies and the IDLE/RUN state encoding.
package mul_div_unit_pkg;

    localparam logic [2:0] MT_DISABLED          = 3'd0;
    localparam logic [2:0] MT_MULTIPLY          = 3'd1;
    localparam logic [2:0] MT_MULTIPLY_UNSIGNED = 3'd2;
    localparam logic [2:0] MT_DIVIDE            = 3'd3;
    localparam logic [2:0] MT_DIVIDE_UNSIGNED   = 3'd4;

    localparam int DEFAULT_MUL_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_divide(input logic [2:0] op);
        return (op == MT_DIVIDE) || (op == MT_DIVIDE_UNSIGNED);
    endfunction

endpackage

// File: rtl/mul_div_compute.sv
// Combinational result generator: 64-bit {hi, lo} for mult/multu/div/divu,
// including the divide-by-zero and signed-overflow cases.
module mul_div_compute
    import mul_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        signed_div;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] a_sx;
    logic [63:0] b_sx;

    always_comb begin
        signed_div = (op == MT_DIVIDE);
        num        = (signed_div && a[31]) ? 32'd0 - a : a;
        den        = (signed_div && b[31]) ? 32'd0 - b : b;
        // keep the divider X-free on a zero divisor; the result is overridden below
        den_safe   = (den == 32'd0) ? 32'd1 : den;
        uq         = num / den_safe;
        ur         = num % den_safe;
        q          = (signed_div && (a[31] ^ b[31])) ? 32'd0 - uq : uq;
        r          = (signed_div && a[31]) ? 32'd0 - ur : ur;
        a_sx       = {{32{a[31]}}, a};
        b_sx       = {{32{b[31]}}, b};

        result = 64'd0;
        case (op)
            MT_MULTIPLY:          result = a_sx * b_sx;
            MT_MULTIPLY_UNSIGNED: result = {32'd0, a} * {32'd0, b};
            MT_DIVIDE, MT_DIVIDE_UNSIGNED: begin
                if (b == 32'd0)
                    result = {a, 32'hFFFF_FFFF};
                else if (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    result = {32'd0, 32'h8000_0000};
                else
                    result = {r, q};
            end
            default:              result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO unit: latches the result at start, counts down the
// fixed latency, then commits to HI/LO.
//   state   | meaning
//   ST_IDLE | counter == 0, ready to accept a request
//   ST_RUN  | counter != 0, result pending; commit when counter == 1
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  mulCtrl,
    input  logic        mulEnable,
    input  logic        mulOutputSel,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        busy,
    output logic [31:0] dataOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [63:0] result;
    logic        start;
    logic        commit;
    state_t      state;

    mul_div_compute u_compute (
        .op     (mulCtrl),
        .a      (operandA),
        .b      (operandB),
        .result (result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            cnt <= cnt_next;
            if (start) begin
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    always_comb begin
        state    = (cnt == 4'd0) ? ST_IDLE : ST_RUN;
        cnt_next = cnt;
        start    = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mulEnable) begin
                    start    = 1'b1;
                    cnt_next = is_divide(mulCtrl) ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                end
            end
            ST_RUN: begin
                // a request arriving here is dropped; the pending result stays intact
                cnt_next = cnt - 4'd1;
                commit   = (cnt == 4'd1);
            end
            default: cnt_next = 4'd0;
        endcase
    end

    always_comb begin
        busy    = mulEnable || (cnt != 4'd0);
        dataOut = mulOutputSel ? hi : lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit with hand-written sequences
// for asynchronous reset mid-operation and an illegal overlapping request.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset_n;
    logic [2:0]  mulCtrl;
    logic        mulEnable;
    logic        mulOutputSel;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic [31:0] dataOut;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap_count = 0;
    int model_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    mul_div_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mulCtrl      (mulCtrl),
        .mulEnable    (mulEnable),
        .mulOutputSel (mulOutputSel),
        .operandA     (operandA),
        .operandB     (operandB),
        .busy         (busy),
        .dataOut      (dataOut),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent occupancy model used to spot a request arriving while an op is pending
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_cnt <= 0;
        end else if (model_cnt == 0) begin
            if (mulEnable)
                model_cnt <= ((mulCtrl == MT_DIVIDE) || (mulCtrl == MT_DIVIDE_UNSIGNED)) ? DIV_N : MUL_N;
        end else begin
            if (mulEnable) overlap_count <= overlap_count + 1;
            model_cnt <= model_cnt - 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input logic [31:0] old_hi, input logic [31:0] old_lo);
        @(posedge clk); #1;
        mulCtrl = v.ctrl; mulEnable = 1'b1; operandA = v.a; operandB = v.b; mulOutputSel = 1'b0;
        @(negedge clk);
        check({v.name, " busy_start"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        // operands change after the start edge must not affect the result
        mulCtrl = MT_DISABLED; mulEnable = 1'b0; operandA = 32'hDEAD_BEEF; operandB = 32'h0000_0003;
        for (int k = 1; k <= v.n; k++) begin
            @(negedge clk);
            check({v.name, " busy_run"}, {31'd0, busy}, 32'd1);
            check({v.name, " hi_before"}, hi, old_hi);
            check({v.name, " lo_before"}, lo, old_lo);
        end
        check({v.name, " dataOut_run"}, dataOut, old_lo);
        @(negedge clk);
        check({v.name, " busy_done"}, {31'd0, busy}, 32'd0);
        check({v.name, " hi"}, hi, v.exp_hi);
        check({v.name, " lo"}, lo, v.exp_lo);
        mulOutputSel = 1'b1; #1;
        check({v.name, " dataOut_hi"}, dataOut, v.exp_hi);
        mulOutputSel = 1'b0; #1;
        check({v.name, " dataOut_lo"}, dataOut, v.exp_lo);
    endtask

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        vecs[0] = '{"mult_m2x3",    MT_MULTIPLY,          32'hFFFF_FFFE, 32'd3,         MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"multu_max",    MT_MULTIPLY_UNSIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div_m7_2",     MT_DIVIDE,            32'hFFFF_FFF9, 32'd2,         DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_m7_2",    MT_DIVIDE_UNSIGNED,   32'hFFFF_FFF9, 32'd2,         DIV_N, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[4] = '{"divu_by_zero", MT_DIVIDE_UNSIGNED,   32'd5,         32'd0,         DIV_N, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5] = '{"div_ovf",      MT_DIVIDE,            32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{"div_by_zero",  MT_DIVIDE,            32'h8000_0000, 32'd0,         DIV_N, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[7] = '{"mult_7xm3",    MT_MULTIPLY,          32'd7,         32'hFFFF_FFFD, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[8] = '{"div_7_m2",     MT_DIVIDE,            32'd7,         32'hFFFF_FFFE, DIV_N, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{"multu_shift",  MT_MULTIPLY_UNSIGNED, 32'h1234_5678, 32'h0000_0010, MUL_N, 32'h0000_0001, 32'h2345_6780};

        reset_n = 1'b0; mulCtrl = MT_DISABLED; mulEnable = 1'b0; mulOutputSel = 1'b0;
        operandA = 32'd0; operandB = 32'd0;
        #3;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset dataOut", dataOut, 32'd0);
        mulEnable = 1'b1; #1;
        check("reset busy_with_enable", {31'd0, busy}, 32'd1);
        mulEnable = 1'b0; #1;
        @(negedge clk); reset_n = 1'b1;

        prev_hi = 32'd0; prev_lo = 32'd0;
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], prev_hi, prev_lo);
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end
        check("no_overlap_in_table", overlap_count, 32'd0);

        // Asynchronous reset in the middle of a divide: nothing may commit afterwards
        @(posedge clk); #1;
        mulCtrl = MT_DIVIDE; mulEnable = 1'b1; operandA = 32'd100; operandB = 32'd7;
        @(posedge clk); #1;
        mulCtrl = MT_DISABLED; mulEnable = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        mulOutputSel = 1'b1; #1;
        check("midrst dataOut_hi", dataOut, 32'd0);
        mulOutputSel = 1'b0;
        @(negedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("postrst busy", {31'd0, busy}, 32'd0);
            check("postrst lo", lo, 32'd0);
            check("postrst hi", hi, 32'd0);
        end

        // Overlapping request: mult in flight, div requested at T+2 must be dropped
        @(posedge clk); #1;
        mulCtrl = MT_MULTIPLY; mulEnable = 1'b1; operandA = 32'd6; operandB = 32'd7;
        @(negedge clk);
        check("ovl busy_T", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        mulCtrl = MT_DISABLED; mulEnable = 1'b0;
        @(posedge clk); #1;
        mulCtrl = MT_DIVIDE; mulEnable = 1'b1; operandA = 32'd100; operandB = 32'd7;
        @(negedge clk);
        check("ovl busy_T2", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        mulCtrl = MT_DISABLED; mulEnable = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            check("ovl busy_run", {31'd0, busy}, 32'd1);
            check("ovl lo_before", lo, 32'd0);
            if (k < 5) @(posedge clk);
        end
        @(negedge clk);
        check("ovl busy_T6", {31'd0, busy}, 32'd0);
        check("ovl hi", hi, 32'd0);
        check("ovl lo", lo, 32'd42);
        repeat (12) @(negedge clk);
        check("ovl busy_late", {31'd0, busy}, 32'd0);
        check("ovl hi_late", hi, 32'd0);
        check("ovl lo_late", lo, 32'd42);
        check("ovl detected", overlap_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage HI/LO arithmetic unit.
- Consumes the decoder's mulCtrl, mulEnable and mulOutputSel fields, together with the forwarded rs/rt operand values.
- Performs mult/multu/div/divu over a fixed multi-cycle latency, holds the architectural HI and LO registers, and supplies mfhi/mflo read data.
- Drives busy to the hazard unit, which stalls D/E while an operation is pending.

Parameters:
- MUL_CYCLES, 5: cycles from the start edge to the HI/LO commit for mult/multu. Legal range 1..15.
- DIV_CYCLES, 10: cycles from the start edge to the HI/LO commit for div/divu. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- mulCtrl  in  3  operation code: mtDisabled / mtMultiply / mtMultiplyUnsigned / mtDivide / mtDivideUnsigned.
- mulEnable  in  1  operation request; equals mulCtrl != mtDisabled.
- mulOutputSel  in  1  read select for dataOut: 1 = HI, 0 = LO.
- operandA  in  32  rs value, already forwarded.
- operandB  in  32  rt value, already forwarded.
- busy  out  1  operation in flight or being accepted this cycle.
- dataOut  out  32  selected HI or LO value, combinational.
- hi  out  32  architectural HI, for debug.
- lo  out  32  architectural LO, for debug.

Behaviour:
- Reset (reset_n low, asynchronous, any cycle including mid-operation):
  - hi, lo, the pending registers and the counter all go to 0.
  - busy reads 0 unless mulEnable is high.
  - Any in-flight operation is discarded and never commits.
- State machine: IDLE (counter == 0) and RUN (counter != 0). Internal 4-bit counter.
- Start, in cycle T when state is IDLE and mulEnable = 1:
  - Result is computed from operandA/operandB in that cycle and latched into pendHi/pendLo at the T edge.
  - counter is loaded with MUL_CYCLES or DIV_CYCLES.
- RUN: counter decrements on each edge. On the edge where counter == 1: hi <= pendHi, lo <= pendLo, counter <= 0.
- Latency: new HI/LO are visible from cycle T+N+1, where N is the loaded cycle count.
- busy = mulEnable OR (counter != 0). It is therefore high in cycles T..T+N.
- mulEnable while RUN:
  - The request is ignored and the pending result is unchanged.
  - The hazard unit must prevent this case; the bench flags it as an assertion failure.
- dataOut = mulOutputSel ? hi : lo.
  - During RUN it returns the old architectural value.
  - mfhi/mflo must be stalled by the hazard unit while busy is high.
- Multiply:
  - mult: full 64-bit signed product {HI, LO}.
  - multu: full 64-bit unsigned product {HI, LO}.
- Divide:
  - LO = quotient, truncated toward zero. HI = remainder, taking the sign of the dividend.
  - div is signed; divu is unsigned.
  - Divide by zero, both signed and unsigned: LO = 32'hFFFFFFFF, HI = operandA. No trap.
  - Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- No exceptions and no overflow flag; checkOverflow does not apply to this unit.

Decomposition:
- Shared constants file:
  - Operation codes: mtDisabled = 0, mtMultiply = 1, mtMultiplyUnsigned = 2, mtDivide = 3, mtDivideUnsigned = 4.
  - Default cycle counts MUL_CYCLES and DIV_CYCLES.
  - The controller and this block both include the file.
- Sub-module mul_div_compute:
  - Purely combinational.
  - Takes the op code and the two operands; produces the 64-bit {hi, lo} result, including the divide-by-zero and signed-overflow special cases.
- The top level holds the counter, the pending registers, the HI/LO registers and the busy/read logic.

Test Plan:
1. mult with A = 32'hFFFFFFFE (-2), B = 3, start cycle T -> busy high T..T+5; at T+6 hi = 32'hFFFFFFFF, lo = 32'hFFFFFFFA; dataOut tracks mulOutputSel.
2. multu with A = 32'hFFFFFFFF, B = 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 1 after 5 cycles; before commit, hi and lo still hold the prior values.
3. div with A = -7, B = 2 -> after 10 cycles lo = 32'hFFFFFFFD (-3), hi = 32'hFFFFFFFF (-1). divu with the same operands -> lo = 32'h7FFFFFFC, hi = 1.
4. Special divides: divu A = 5, B = 0 -> lo = 32'hFFFFFFFF, hi = 5. div A = 32'h80000000, B = 32'hFFFFFFFF -> lo = 32'h80000000, hi = 0.
5. Start div, pulse reset_n low at T+4 -> all outputs 0 immediately. After release, busy = 0 and no commit ever occurs.
6. Start mult; assert mulEnable again with div at T+2 -> request ignored; mult result commits at T+5 edge; busy drops at T+6; assertion flags the illegal overlap.
